stc_a_dn_mc: RTL and testbench

//  Next-generation A-operand distribution network for the sparse tensor core.

---
 rtl/stc_a_dn_mc_if.sv | 35 +++
 rtl/stc_a_dn_mc.sv | 100 ++++++++++
 tb/tb_stc_a_dn_mc.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/stc_a_dn_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : stc_a_dn_mc_if
//  Purpose  : Upstream/downstream handshake bundle for the A-operand network.
//  Revision : 1.0 - initial release
// ============================================================================
interface stc_a_dn_mc_if #(
  parameter int N       = 16,
  parameter int DW_DATA = 16,
  parameter int N_PE    = 4,
  parameter int MAX_REP = 8
);
  localparam int RW = $clog2(MAX_REP) + 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [N_PE*DW_DATA-1:0]     in_a;
  logic [N_PE*N-1:0]           in_mask;
  logic [RW-1:0]               in_rep;
  logic                        out_valid;
  logic                        out_ready;
  logic [N_PE*N*DW_DATA-1:0]   out_a;
  logic                        out_last;

  modport master (
    output in_valid, in_a, in_mask, in_rep, out_ready,
    input  in_ready, out_valid, out_a, out_last
  );

  modport slave (
    input  in_valid, in_a, in_mask, in_rep, out_ready,
    output in_ready, out_valid, out_a, out_last
  );
endinterface
`default_nettype wire

// File: rtl/stc_a_dn_mc.sv
`default_nettype none
// ============================================================================
//  Module   : stc_a_dn_mc
//  Purpose  : Replicates each PE's A element onto its mask-gated lanes and
//             presents the vector for a programmable number of beats.
//  Revision : 1.0 - initial release
// ============================================================================
module stc_a_dn_mc #(
  parameter int N       = 16,
  parameter int DW_DATA = 16,
  parameter int N_PE    = 4,
  parameter int MAX_REP = 8
) (
  input  logic              clk,
  input  logic              reset,
  stc_a_dn_mc_if.slave      bus
);
  localparam int              RW        = $clog2(MAX_REP) + 1;
  localparam logic [RW-1:0]   c_max_rep = RW'(MAX_REP);
  localparam logic [RW-1:0]   c_one     = RW'(1);

  localparam logic [0:0]      S_IDLE    = 1'b0;
  localparam logic [0:0]      S_HOLD    = 1'b1;

  logic [0:0]                 r_state;
  logic [0:0]                 w_state_nxt;
  logic [RW-1:0]              r_cnt;
  logic [N_PE*N*DW_DATA-1:0]  r_out_a;
  logic [N_PE*N*DW_DATA-1:0]  w_lane_map;
  logic [RW-1:0]              w_eff_rep;
  logic                       w_out_valid;
  logic                       w_in_ready;
  logic                       w_out_last;
  logic                       w_accept;
  logic                       w_beat;
  logic                       w_cnt_zero;

  generate
    for (genvar p = 0; p < N_PE; p++) begin : g_pe
      for (genvar j = 0; j < N; j++) begin : g_lane
        assign w_lane_map[(p*N+j)*DW_DATA +: DW_DATA] =
          bus.in_mask[p*N+j] ? bus.in_a[p*DW_DATA +: DW_DATA] : '0;
      end
    end
  endgenerate

  // Zero means a single beat; oversize requests saturate.
  always_comb begin
    w_eff_rep = bus.in_rep;
    if (bus.in_rep == '0)
      w_eff_rep = c_one;
    else if (bus.in_rep > c_max_rep)
      w_eff_rep = c_max_rep;
  end

  assign w_cnt_zero = (r_cnt == '0);
  assign w_beat     = w_out_valid && bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_HOLD;
      S_HOLD: if (w_beat && w_cnt_zero && !w_accept) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // in_ready on the final beat lets the next vector follow without a bubble.
  always_comb begin
    w_out_valid = (r_state == S_HOLD);
    w_out_last  = w_out_valid && w_cnt_zero;
    w_in_ready  = reset && ((r_state == S_IDLE) || (w_beat && w_cnt_zero));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_out_a <= '0;
    end else if (w_accept) begin
      r_cnt   <= w_eff_rep - c_one;
      r_out_a <= w_lane_map;
    end else if (w_beat && !w_cnt_zero) begin
      r_cnt   <= r_cnt - c_one;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_a     = r_out_a;
  assign bus.out_last  = w_out_last;
endmodule
`default_nettype wire

// File: tb/tb_stc_a_dn_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stc_a_dn_mc
//  Purpose  : Directed self-checking bench for the A-operand network.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stc_a_dn_mc;
  localparam int N       = 16;
  localparam int DW_DATA = 16;
  localparam int N_PE    = 4;
  localparam int MAX_REP = 8;
  localparam int AW      = N_PE*N*DW_DATA;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  stc_a_dn_mc_if #(.N(N), .DW_DATA(DW_DATA), .N_PE(N_PE), .MAX_REP(MAX_REP)) bus ();

  stc_a_dn_mc #(.N(N), .DW_DATA(DW_DATA), .N_PE(N_PE), .MAX_REP(MAX_REP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [AW-1:0] exp);
    logic [AW-1:0] obs;
    obs = bus.out_a;
    for (int p = 0; p < N_PE; p++)
      check($sformatf("%s_pe%0d", tag, p), obs[p*256 +: 256], exp[p*256 +: 256]);
  endtask

  task automatic check_ctl(input string tag, input logic v, input logic l, input logic r);
    check({tag, "_valid"}, 256'(bus.out_valid), 256'(v));
    check({tag, "_last"},  256'(bus.out_last),  256'(l));
    check({tag, "_ready"}, 256'(bus.in_ready),  256'(r));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] exp_a, exp_b, exp_m;
  int beats;

  initial begin
    checks = 0;
    errors = 0;
    // Vector A {3,7,9,1}, all lanes on; vector B {4,5,6,8}, all lanes on.
    exp_a = {{16{16'd3}}, {16{16'd7}}, {16{16'd9}}, {16{16'd1}}};
    exp_b = {{16{16'd4}}, {16{16'd5}}, {16{16'd6}}, {16{16'd8}}};
    exp_m = '0;
    exp_m[15:0]  = 16'd1;
    exp_m[47:32] = 16'd1;

    reset         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = {16'd3, 16'd7, 16'd9, 16'd1};
    bus.in_mask   = '1;
    bus.in_rep    = 4'd1;
    bus.out_ready = 1'b1;

    // Reset held with in_valid high: nothing accepted.
    tick();
    check_ctl("rst1", 1'b0, 1'b0, 1'b0);
    check_a("rst1_a", '0);
    tick();
    check_ctl("rst2", 1'b0, 1'b0, 1'b0);
    check_a("rst2_a", '0);
    reset = 1'b1;
    #1;
    check("idle_ready", 256'(bus.in_ready), 256'd1);

    // Single-beat full-mask vector.
    tick();
    check_ctl("t2_beat", 1'b1, 1'b1, 1'b1);
    check_a("t2_a", exp_a);
    bus.in_valid = 1'b0;
    tick();
    check("t2_idle", 256'(bus.out_valid), 256'd0);

    // Sparse mask on PE0 only.
    bus.in_mask  = {48'h0, 16'h0005};
    bus.in_valid = 1'b1;
    tick();
    check_ctl("t3_beat", 1'b1, 1'b1, 1'b1);
    check_a("t3_a", exp_m);
    bus.in_valid = 1'b0;
    tick();
    check("t3_idle", 256'(bus.out_valid), 256'd0);

    // rep=3 followed back-to-back by vector B with rep=1.
    bus.in_mask  = '1;
    bus.in_rep   = 4'd3;
    bus.in_valid = 1'b1;
    tick();
    bus.in_a   = {16'd4, 16'd5, 16'd6, 16'd8};
    bus.in_rep = 4'd1;
    #1;
    check_ctl("t4_b1", 1'b1, 1'b0, 1'b0);
    check_a("t4_b1_a", exp_a);
    tick();
    check_ctl("t4_b2", 1'b1, 1'b0, 1'b0);
    check_a("t4_b2_a", exp_a);
    tick();
    check_ctl("t4_b3", 1'b1, 1'b1, 1'b1);
    check_a("t4_b3_a", exp_a);
    tick();
    check_ctl("t4_vb", 1'b1, 1'b1, 1'b1);
    check_a("t4_vb_a", exp_b);
    bus.in_valid = 1'b0;
    tick();
    check("t4_idle", 256'(bus.out_valid), 256'd0);

    // rep=4 with four stalled cycles after beat 2.
    bus.in_a     = {16'd3, 16'd7, 16'd9, 16'd1};
    bus.in_rep   = 4'd4;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check_ctl("t5_b1", 1'b1, 1'b0, 1'b0);
    tick();
    check_ctl("t5_b2", 1'b1, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_ctl($sformatf("t5_stall%0d", i), 1'b1, 1'b0, 1'b0);
      check_a($sformatf("t5_stall%0d_a", i), exp_a);
    end
    bus.out_ready = 1'b1;
    tick();
    check_ctl("t5_b3", 1'b1, 1'b0, 1'b0);
    tick();
    check_ctl("t5_b4", 1'b1, 1'b1, 1'b1);
    check_a("t5_b4_a", exp_a);
    tick();
    check("t5_idle", 256'(bus.out_valid), 256'd0);

    // rep=0 gives one beat.
    bus.in_rep   = 4'd0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check_ctl("t6_rep0", 1'b1, 1'b1, 1'b1);
    tick();
    check("t6_rep0_idle", 256'(bus.out_valid), 256'd0);

    // rep=15 saturates to 8 beats; last only on the eighth.
    bus.in_rep   = 4'd15;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    beats = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin
        beats++;
        check($sformatf("t6_sat_last%0d", beats), 256'(bus.out_last), 256'(beats == 8));
      end
      tick();
    end
    check("t6_sat_beats", 256'(beats), 256'd8);

    // Reset in the middle of a hold drops the remaining beats.
    bus.in_rep   = 4'd4;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check_ctl("t6_pre_rst", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_ctl("t6_in_rst", 1'b0, 1'b0, 1'b0);
    check_a("t6_in_rst_a", '0);
    reset = 1'b1;
    tick();
    check("t6_post_rst", 256'(bus.out_valid), 256'd0);
    tick();
    check("t6_post_rst2", 256'(bus.out_valid), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
